dmem_issue_unit: RTL and testbench

- Parametrised data-access issue unit between EXE and the data-SRAM-like bus.
- Holds one memory op, translates its address (direct mode, NUM_DMW direct-map windows, or TLB) and flags ALE/TLBR/PIL/PIS/PPI/PME.
- Issues up to MAX_OUTST outstanding requests. The previous one-request-at-a-time EXE access could not do this.
- On flush, tracks and discards responses that were already in flight.

---
 rtl/dmem_issue_unit_pkg.sv | 60 ++++++
 rtl/dmem_addr_xlate.sv | 85 ++++++++
 rtl/dmem_issue_unit.sv | 173 +++++++++++++++++
 tb/tb_dmem_issue_unit.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_issue_unit_pkg.sv
// Shared encodings for the data-memory issue unit: access sizes, exception vector layout,
// the held-op payload and store formatting helpers.
package dmem_issue_unit_pkg;

  localparam int unsigned VADDR_W = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned VPPN_W  = 19;
  localparam int unsigned PPN_W   = 20;
  localparam int unsigned PS_W    = 6;
  localparam int unsigned EXCP_W  = 6;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] PLV_KERNEL = 2'd0;
  localparam logic [1:0] PLV_USER   = 2'd3;

  // Bit positions inside excp_vec = {ALE,TLBR,PIL,PIS,PPI,PME}
  localparam int unsigned EXCP_ALE  = 5;
  localparam int unsigned EXCP_TLBR = 4;
  localparam int unsigned EXCP_PIL  = 3;
  localparam int unsigned EXCP_PIS  = 2;
  localparam int unsigned EXCP_PPI  = 1;
  localparam int unsigned EXCP_PME  = 0;

  localparam logic [PS_W-1:0] PS_4M = 6'd21;

  typedef struct packed {
    logic               store;
    logic [1:0]         size;
    logic [VADDR_W-1:0] vaddr;
    logic [DATA_W-1:0]  wdata;
  } mem_op_t;

  function automatic logic [STRB_W-1:0] fmt_wstrb(input logic [1:0] sz, input logic [1:0] off);
    logic [STRB_W-1:0] strb;
    strb = 4'b1111;
    case (sz)
      SIZE_BYTE: strb = 4'b0001 << off;
      SIZE_HALF: strb = off[1] ? 4'b1100 : 4'b0011;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Replicate the low lanes so the bus can pick any byte lane by wstrb
  function automatic logic [DATA_W-1:0] fmt_wdata(input logic [1:0] sz, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] w;
    w = d;
    case (sz)
      SIZE_BYTE: w = {4{d[7:0]}};
      SIZE_HALF: w = {2{d[15:0]}};
      default:   w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dmem_addr_xlate.sv
// Combinational address translation for one held memory op: direct mode, direct-map windows
// or TLB, producing the physical address, the MAT bit and the exception vector.
module dmem_addr_xlate
  import dmem_issue_unit_pkg::*;
#(
  parameter int unsigned NUM_DMW = 2
) (
  input  logic                 store,
  input  logic [1:0]           size,
  input  logic [VADDR_W-1:0]   vaddr,
  input  logic                 crmd_da,
  input  logic                 crmd_pg,
  input  logic [1:0]           crmd_datm,
  input  logic [1:0]           cur_plv,
  input  logic [3*NUM_DMW-1:0] dmw_vseg,
  input  logic [3*NUM_DMW-1:0] dmw_pseg,
  input  logic [NUM_DMW-1:0]   dmw_plv0,
  input  logic [NUM_DMW-1:0]   dmw_plv3,
  input  logic [NUM_DMW-1:0]   dmw_mat0,
  input  logic                 tlb_found,
  input  logic                 tlb_v,
  input  logic                 tlb_d,
  input  logic [PPN_W-1:0]     tlb_ppn,
  input  logic [PS_W-1:0]      tlb_ps,
  input  logic [1:0]           tlb_plv,
  input  logic [1:0]           tlb_mat,
  output logic [VADDR_W-1:0]   paddr,
  output logic                 mat,
  output logic [EXCP_W-1:0]    excp_vec
);

  logic               direct;
  logic               dmw_hit;
  logic [VADDR_W-1:0] dmw_addr;
  logic               dmw_mat;
  logic [VADDR_W-1:0] tlb_addr;
  logic               ale;
  logic               unused_hi_bits;

  assign direct = crmd_da & ~crmd_pg;

  // Scan from the top so the lowest-index matching window is the one that sticks
  always_comb begin
    dmw_hit  = 1'b0;
    dmw_addr = '0;
    dmw_mat  = 1'b0;
    for (int i = int'(NUM_DMW) - 1; i >= 0; i--) begin
      if (dmw_vseg[3*i +: 3] == vaddr[31:29] &&
          ((dmw_plv3[i] && cur_plv == PLV_USER) || (dmw_plv0[i] && cur_plv == PLV_KERNEL))) begin
        dmw_hit  = 1'b1;
        dmw_addr = {dmw_pseg[3*i +: 3], vaddr[28:0]};
        dmw_mat  = dmw_mat0[i];
      end
    end
  end

  assign tlb_addr = (tlb_ps == PS_4M) ? {tlb_ppn[19:9], vaddr[20:0]}
                                      : {tlb_ppn, vaddr[11:0]};

  assign ale = ((size == SIZE_HALF) && vaddr[0]) ||
               ((size == SIZE_WORD) && (vaddr[1:0] != 2'b00));

  always_comb begin
    paddr    = tlb_addr;
    mat      = tlb_mat[0];
    excp_vec = '0;
    excp_vec[EXCP_ALE] = ale;
    if (direct) begin
      paddr = vaddr;
      mat   = crmd_datm[0];
    end else if (dmw_hit) begin
      paddr = dmw_addr;
      mat   = dmw_mat;
    end else begin
      excp_vec[EXCP_TLBR] = ~tlb_found;
      excp_vec[EXCP_PIL]  = ~store & tlb_found & ~tlb_v;
      excp_vec[EXCP_PIS]  =  store & tlb_found & ~tlb_v;
      excp_vec[EXCP_PPI]  = tlb_found & tlb_v & (cur_plv > tlb_plv);
      excp_vec[EXCP_PME]  = store & tlb_found & tlb_v & (cur_plv <= tlb_plv) & ~tlb_d;
    end
  end

  assign unused_hi_bits = ^{crmd_datm[1], tlb_mat[1]};

endmodule

// File: rtl/dmem_issue_unit.sv
// Data-access issue unit: holds one EXE memory op, translates and checks it, and issues it
// to the data bus with up to MAX_OUTST requests in flight; drops responses orphaned by a flush.
module dmem_issue_unit
  import dmem_issue_unit_pkg::*;
#(
  parameter int unsigned NUM_DMW   = 2,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned CNT_W     = $clog2(MAX_OUTST) + 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_store,
  input  logic [1:0]           in_size,
  input  logic [VADDR_W-1:0]   in_vaddr,
  input  logic [DATA_W-1:0]    in_wdata,
  input  logic                 crmd_da,
  input  logic                 crmd_pg,
  input  logic [1:0]           crmd_datm,
  input  logic [1:0]           cur_plv,
  input  logic [3*NUM_DMW-1:0] dmw_vseg,
  input  logic [3*NUM_DMW-1:0] dmw_pseg,
  input  logic [NUM_DMW-1:0]   dmw_plv0,
  input  logic [NUM_DMW-1:0]   dmw_plv3,
  input  logic [NUM_DMW-1:0]   dmw_mat0,
  output logic [VPPN_W-1:0]    tlb_vppn,
  output logic                 tlb_va_bit12,
  input  logic                 tlb_found,
  input  logic                 tlb_v,
  input  logic                 tlb_d,
  input  logic [PPN_W-1:0]     tlb_ppn,
  input  logic [PS_W-1:0]      tlb_ps,
  input  logic [1:0]           tlb_plv,
  input  logic [1:0]           tlb_mat,
  output logic                 req,
  output logic                 wr,
  output logic [1:0]           size,
  output logic [STRB_W-1:0]    wstrb,
  output logic [VADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]    wdata,
  output logic                 mat,
  input  logic                 addr_ok,
  input  logic                 data_ok,
  output logic                 rsp_valid,
  output logic                 excp_valid,
  output logic [EXCP_W-1:0]    excp_vec
);

  logic               hold_valid;
  logic               hold_valid_next;
  mem_op_t            hold;
  mem_op_t            hold_next;
  logic [CNT_W-1:0]   outst;
  logic [CNT_W-1:0]   outst_next;
  logic [CNT_W-1:0]   discard;
  logic [CNT_W-1:0]   discard_next;

  logic [VADDR_W-1:0] xl_addr;
  logic               xl_mat;
  logic [EXCP_W-1:0]  xl_vec;
  logic               fault;
  logic               room;
  logic               issue_fire;
  logic               capture;

  dmem_addr_xlate #(
    .NUM_DMW (NUM_DMW)
  ) u_xlate (
    .store     (hold.store),
    .size      (hold.size),
    .vaddr     (hold.vaddr),
    .crmd_da   (crmd_da),
    .crmd_pg   (crmd_pg),
    .crmd_datm (crmd_datm),
    .cur_plv   (cur_plv),
    .dmw_vseg  (dmw_vseg),
    .dmw_pseg  (dmw_pseg),
    .dmw_plv0  (dmw_plv0),
    .dmw_plv3  (dmw_plv3),
    .dmw_mat0  (dmw_mat0),
    .tlb_found (tlb_found),
    .tlb_v     (tlb_v),
    .tlb_d     (tlb_d),
    .tlb_ppn   (tlb_ppn),
    .tlb_ps    (tlb_ps),
    .tlb_plv   (tlb_plv),
    .tlb_mat   (tlb_mat),
    .paddr     (xl_addr),
    .mat       (xl_mat),
    .excp_vec  (xl_vec)
  );

  // Handshake: a faulting op leaves the hold in the same cycle it reports
  assign fault      = |xl_vec;
  assign room       = outst < CNT_W'(MAX_OUTST);
  assign req        = hold_valid & ~fault & ~flush & room;
  assign issue_fire = req & addr_ok;
  assign excp_valid = hold_valid & fault & ~flush;
  assign excp_vec   = excp_valid ? xl_vec : '0;
  assign in_ready   = ~hold_valid | issue_fire | excp_valid;
  assign capture    = in_valid & in_ready & ~flush;
  assign rsp_valid  = data_ok & (discard == '0);

  assign tlb_vppn     = hold.vaddr[31:13];
  assign tlb_va_bit12 = hold.vaddr[12];

  always_comb begin
    wr    = 1'b0;
    size  = '0;
    wstrb = '0;
    addr  = '0;
    wdata = '0;
    mat   = 1'b0;
    if (hold_valid) begin
      wr    = hold.store;
      size  = hold.size;
      wstrb = hold.store ? fmt_wstrb(hold.size, hold.vaddr[1:0]) : '0;
      addr  = xl_addr;
      wdata = fmt_wdata(hold.size, hold.wdata);
      mat   = xl_mat;
    end
  end

  // Next-state for the hold register and the in-flight / discard counters
  always_comb begin
    hold_valid_next = hold_valid;
    hold_next       = hold;
    outst_next      = outst + CNT_W'(issue_fire) - CNT_W'(data_ok);
    discard_next    = discard;

    if (flush) begin
      hold_valid_next = 1'b0;
    end else if (capture) begin
      hold_valid_next = 1'b1;
    end else if (issue_fire || excp_valid) begin
      hold_valid_next = 1'b0;
    end

    if (capture) begin
      hold_next.store = in_store;
      hold_next.size  = in_size;
      hold_next.vaddr = in_vaddr;
      hold_next.wdata = in_wdata;
    end

    // Everything still in flight at the flush belongs to squashed instructions
    if (flush) begin
      discard_next = outst_next;
    end else if (data_ok && discard != '0) begin
      discard_next = discard - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_valid <= 1'b0;
      hold       <= '0;
      outst      <= '0;
      discard    <= '0;
    end else begin
      hold_valid <= hold_valid_next;
      hold       <= hold_next;
      outst      <= outst_next;
      discard    <= discard_next;
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!resetn)
    !(data_ok && outst == '0));

endmodule

// File: tb/tb_dmem_issue_unit.sv
// Directed bench for dmem_issue_unit: direct/DMW/TLB translation, outstanding limit,
// fault reporting and flush-time response discarding.
module tb_dmem_issue_unit;
  import dmem_issue_unit_pkg::*;

  localparam int unsigned NUM_DMW   = 2;
  localparam int unsigned MAX_OUTST = 4;
  localparam int unsigned CNT_W     = $clog2(MAX_OUTST) + 1;

  logic                 clk;
  logic                 resetn;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_store;
  logic [1:0]           in_size;
  logic [31:0]          in_vaddr;
  logic [31:0]          in_wdata;
  logic                 crmd_da;
  logic                 crmd_pg;
  logic [1:0]           crmd_datm;
  logic [1:0]           cur_plv;
  logic [3*NUM_DMW-1:0] dmw_vseg;
  logic [3*NUM_DMW-1:0] dmw_pseg;
  logic [NUM_DMW-1:0]   dmw_plv0;
  logic [NUM_DMW-1:0]   dmw_plv3;
  logic [NUM_DMW-1:0]   dmw_mat0;
  logic [18:0]          tlb_vppn;
  logic                 tlb_va_bit12;
  logic                 tlb_found;
  logic                 tlb_v;
  logic                 tlb_d;
  logic [19:0]          tlb_ppn;
  logic [5:0]           tlb_ps;
  logic [1:0]           tlb_plv;
  logic [1:0]           tlb_mat;
  logic                 req;
  logic                 wr;
  logic [1:0]           size;
  logic [3:0]           wstrb;
  logic [31:0]          addr;
  logic [31:0]          wdata;
  logic                 mat;
  logic                 addr_ok;
  logic                 data_ok;
  logic                 rsp_valid;
  logic                 excp_valid;
  logic [5:0]           excp_vec;

  int n_checks = 0;
  int n_errors = 0;

  dmem_issue_unit #(
    .NUM_DMW   (NUM_DMW),
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_store     (in_store),
    .in_size      (in_size),
    .in_vaddr     (in_vaddr),
    .in_wdata     (in_wdata),
    .crmd_da      (crmd_da),
    .crmd_pg      (crmd_pg),
    .crmd_datm    (crmd_datm),
    .cur_plv      (cur_plv),
    .dmw_vseg     (dmw_vseg),
    .dmw_pseg     (dmw_pseg),
    .dmw_plv0     (dmw_plv0),
    .dmw_plv3     (dmw_plv3),
    .dmw_mat0     (dmw_mat0),
    .tlb_vppn     (tlb_vppn),
    .tlb_va_bit12 (tlb_va_bit12),
    .tlb_found    (tlb_found),
    .tlb_v        (tlb_v),
    .tlb_d        (tlb_d),
    .tlb_ppn      (tlb_ppn),
    .tlb_ps       (tlb_ps),
    .tlb_plv      (tlb_plv),
    .tlb_mat      (tlb_mat),
    .req          (req),
    .wr           (wr),
    .size         (size),
    .wstrb        (wstrb),
    .addr         (addr),
    .wdata        (wdata),
    .mat          (mat),
    .addr_ok      (addr_ok),
    .data_ok      (data_ok),
    .rsp_valid    (rsp_valid),
    .excp_valid   (excp_valid),
    .excp_vec     (excp_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic offer(input logic st, input logic [1:0] sz, input logic [31:0] va, input logic [31:0] wd);
    in_valid = 1'b1;
    in_store = st;
    in_size  = sz;
    in_vaddr = va;
    in_wdata = wd;
  endtask

  // One faulting op through the TLB path: reports once, then the hold is free
  task automatic run_fault(input string tag, input logic st, input logic [1:0] sz, input logic [31:0] va,
                           input logic fnd, input logic v, input logic d, input logic [1:0] tplv,
                           input logic [5:0] exp_vec);
    tlb_found = fnd;
    tlb_v     = v;
    tlb_d     = d;
    tlb_plv   = tplv;
    offer(st, sz, va, 32'h0);
    tick();
    in_valid = 1'b0;
    settle();
    check({tag, "_excp_valid"}, 32'(excp_valid), 32'd1);
    check({tag, "_excp_vec"}, 32'(excp_vec), 32'(exp_vec));
    check({tag, "_req"}, 32'(req), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    settle();
    check({tag, "_pulse_end"}, 32'(excp_valid), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_store = 1'b0; in_size = SIZE_WORD;
    in_vaddr = '0; in_wdata = '0; crmd_da = 1'b1; crmd_pg = 1'b0; crmd_datm = 2'b01; cur_plv = 2'd0;
    dmw_vseg = '0; dmw_pseg = '0; dmw_plv0 = '0; dmw_plv3 = '0; dmw_mat0 = '0;
    tlb_found = 1'b0; tlb_v = 1'b0; tlb_d = 1'b0; tlb_ppn = '0; tlb_ps = 6'd12; tlb_plv = 2'd0;
    tlb_mat = 2'b00; addr_ok = 1'b0; data_ok = 1'b0;

    tick();
    tick();
    resetn = 1'b1;
    settle();
    check("rst_req", 32'(req), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_excp_valid", 32'(excp_valid), 32'd0);
    check("rst_excp_vec", 32'(excp_vec), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_outst", 32'(dut.outst), 32'd0);
    check("rst_discard", 32'(dut.discard), 32'd0);

    // Direct mode word store, then a half store
    offer(1'b1, SIZE_WORD, 32'h1C00_0004, 32'hDEAD_BEEF);
    tick();
    in_valid = 1'b0;
    addr_ok  = 1'b1;
    settle();
    check("t1_req", 32'(req), 32'd1);
    check("t1_wr", 32'(wr), 32'd1);
    check("t1_addr", addr, 32'h1C00_0004);
    check("t1_wstrb", 32'(wstrb), 32'hF);
    check("t1_wdata", wdata, 32'hDEAD_BEEF);
    check("t1_size", 32'(size), 32'd2);
    check("t1_mat", 32'(mat), 32'd1);
    tick();
    addr_ok = 1'b0;
    settle();
    check("t1_req_done", 32'(req), 32'd0);
    check("t1_outst1", 32'(dut.outst), 32'd1);
    data_ok = 1'b1;
    settle();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
    data_ok = 1'b0;
    settle();
    check("t1_outst0", 32'(dut.outst), 32'd0);

    offer(1'b1, SIZE_HALF, 32'h1C00_0006, 32'h0000_1234);
    tick();
    in_valid = 1'b0;
    addr_ok  = 1'b1;
    settle();
    check("t1h_wstrb", 32'(wstrb), 32'hC);
    check("t1h_wdata", wdata, 32'h1234_1234);
    check("t1h_addr", addr, 32'h1C00_0006);
    tick();
    addr_ok = 1'b0;
    data_ok = 1'b1;
    tick();
    data_ok = 1'b0;

    // DMW1 byte store; then both windows match and window 0 must win
    crmd_da = 1'b0; crmd_pg = 1'b1; cur_plv = 2'd0;
    dmw_vseg = {3'd5, 3'd1}; dmw_pseg = {3'd0, 3'd7};
    dmw_plv0 = 2'b11; dmw_plv3 = 2'b00; dmw_mat0 = 2'b10; tlb_found = 1'b0;
    offer(1'b1, SIZE_BYTE, 32'hA000_0003, 32'h0000_005A);
    tick();
    in_valid = 1'b0;
    settle();
    check("t2_addr", addr, 32'h0000_0003);
    check("t2_wstrb", 32'(wstrb), 32'h8);
    check("t2_wdata", wdata, 32'h5A5A_5A5A);
    check("t2_mat", 32'(mat), 32'd1);
    check("t2_excp", 32'(excp_valid), 32'd0);
    check("t2_req", 32'(req), 32'd1);
    dmw_vseg = {3'd5, 3'd5};
    settle();
    check("t2_low_win_addr", addr, 32'hE000_0003);
    check("t2_low_win_mat", 32'(mat), 32'd0);
    cur_plv = 2'd3;
    settle();
    check("t2_miss_tlbr", 32'(excp_vec), 32'h10);
    check("t2_miss_req", 32'(req), 32'd0);
    cur_plv = 2'd0;
    dmw_vseg = {3'd5, 3'd1};
    addr_ok = 1'b1;
    settle();
    tick();
    addr_ok = 1'b0;
    data_ok = 1'b1;
    tick();
    data_ok = 1'b0;

    // Five back-to-back loads against a limit of four
    crmd_da = 1'b1; crmd_pg = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(1'b0, SIZE_WORD, 32'h100 + 32'(4 * i), 32'h0);
      addr_ok = 1'b1;
      settle();
      if (i == 0) begin
        check("t3_req_empty", 32'(req), 32'd0);
      end else begin
        check("t3_req", 32'(req), 32'd1);
        check("t3_addr", addr, 32'h100 + 32'(4 * (i - 1)));
        check("t3_in_ready", 32'(in_ready), 32'd1);
      end
      tick();
    end
    in_valid = 1'b0;
    settle();
    check("t3_full_req", 32'(req), 32'd0);
    check("t3_full_in_ready", 32'(in_ready), 32'd0);
    check("t3_full_outst", 32'(dut.outst), 32'd4);
    data_ok = 1'b1;
    settle();
    check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t3_req_same_cycle", 32'(req), 32'd0);
    tick();
    data_ok = 1'b0;
    settle();
    check("t3_fifth_req", 32'(req), 32'd1);
    check("t3_fifth_addr", addr, 32'h0000_0110);
    check("t3_load_wr", 32'(wr), 32'd0);
    check("t3_load_wstrb", 32'(wstrb), 32'h0);
    tick();
    addr_ok = 1'b0;
    settle();
    check("t3_outst_refill", 32'(dut.outst), 32'd4);
    data_ok = 1'b1;
    repeat (4) tick();
    data_ok = 1'b0;
    settle();
    check("t3_drained", 32'(dut.outst), 32'd0);

    // Paged-mode faults through the TLB path
    crmd_da = 1'b0; crmd_pg = 1'b1; cur_plv = 2'd3;
    dmw_plv0 = 2'b00; dmw_plv3 = 2'b00; tlb_ps = 6'd12;
    run_fault("t4_pme",  1'b1, SIZE_WORD, 32'h0040_0000, 1'b1, 1'b1, 1'b0, 2'd3, 6'b000001);
    run_fault("t4_ale",  1'b0, SIZE_HALF, 32'h0040_0001, 1'b1, 1'b1, 1'b0, 2'd3, 6'b100000);
    run_fault("t4_ppi",  1'b0, SIZE_WORD, 32'h0040_0004, 1'b1, 1'b1, 1'b1, 2'd0, 6'b000010);
    run_fault("t4_tlbr", 1'b0, SIZE_WORD, 32'h0040_0008, 1'b0, 1'b0, 1'b0, 2'd3, 6'b010000);
    run_fault("t4_pis",  1'b1, SIZE_WORD, 32'h0040_000C, 1'b1, 1'b0, 1'b0, 2'd3, 6'b000100);
    run_fault("t4_pil",  1'b0, SIZE_BYTE, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 2'd3, 6'b001000);
    run_fault("t4_ale_tlbr", 1'b1, SIZE_HALF, 32'h0040_0003, 1'b0, 1'b0, 1'b0, 2'd3, 6'b110000);

    tlb_found = 1'b1; tlb_v = 1'b1; tlb_d = 1'b0; tlb_plv = 2'd3;
    offer(1'b1, SIZE_WORD, 32'h0040_0020, 32'h0);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    settle();
    check("t4_flush_excp", 32'(excp_valid), 32'd0);
    check("t4_flush_vec", 32'(excp_vec), 32'd0);
    check("t4_flush_req", 32'(req), 32'd0);
    tick();
    flush = 1'b0;
    settle();
    check("t4_flush_freed", 32'(in_ready), 32'd1);
    check("t4_flush_no_excp", 32'(excp_valid), 32'd0);

    // Flush with three in flight and a response arriving in the flush cycle
    crmd_da = 1'b1; crmd_pg = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b0, SIZE_WORD, 32'h200 + 32'(4 * i), 32'h0);
      addr_ok = 1'b1;
      tick();
    end
    offer(1'b0, SIZE_WORD, 32'h0000_0280, 32'h0);
    addr_ok = 1'b0;
    flush   = 1'b1;
    data_ok = 1'b1;
    settle();
    check("t5_f_req", 32'(req), 32'd0);
    check("t5_f_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t5_f_excp", 32'(excp_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    data_ok  = 1'b0;
    settle();
    check("t5_hold_cleared", 32'(req), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_outst", 32'(dut.outst), 32'd2);
    check("t5_discard", 32'(dut.discard), 32'd2);
    data_ok = 1'b1;
    settle();
    check("t5_drop1", 32'(rsp_valid), 32'd0);
    tick();
    settle();
    check("t5_drop2", 32'(rsp_valid), 32'd0);
    tick();
    data_ok = 1'b0;
    settle();
    check("t5_discard0", 32'(dut.discard), 32'd0);
    check("t5_outst0", 32'(dut.outst), 32'd0);
    offer(1'b0, SIZE_WORD, 32'h0000_0300, 32'h0);
    tick();
    in_valid = 1'b0;
    addr_ok  = 1'b1;
    settle();
    check("t5_new_req", 32'(req), 32'd1);
    tick();
    addr_ok = 1'b0;
    data_ok = 1'b1;
    settle();
    check("t5_new_rsp", 32'(rsp_valid), 32'd1);
    tick();
    data_ok = 1'b0;

    // 4 MB page hit; held op must stay stable while addr_ok is low
    crmd_da = 1'b0; crmd_pg = 1'b1; cur_plv = 2'd0;
    tlb_found = 1'b1; tlb_v = 1'b1; tlb_d = 1'b1; tlb_plv = 2'd0;
    tlb_ps = 6'd21; tlb_ppn = 20'hABCDE; tlb_mat = 2'b01;
    offer(1'b0, SIZE_BYTE, 32'h0012_3456, 32'h0);
    tick();
    offer(1'b0, SIZE_WORD, 32'h0099_9990, 32'h0);
    settle();
    check("t6_addr_4m", addr, 32'hABD2_3456);
    check("t6_mat", 32'(mat), 32'd1);
    check("t6_vppn", 32'(tlb_vppn), 32'h91);
    check("t6_bit12", 32'(tlb_va_bit12), 32'd1);
    check("t6_req", 32'(req), 32'd1);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    settle();
    check("t6_stable", addr, 32'hABD2_3456);
    tlb_ps = 6'd12;
    settle();
    check("t6_addr_4k", addr, 32'hABCD_E456);
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    data_ok = 1'b1;
    settle();
    check("t6_rsp", 32'(rsp_valid), 32'd1);
    tick();
    data_ok = 1'b0;
    settle();
    check("t6_idle", 32'(dut.outst), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
